// File: rtl/onehot_dec_pkg.sv
// Shared constants, state encoding and index decode helper for the
// sequential 3-to-8 one-hot decoder.
package onehot_dec_pkg;

   localparam int IDX_W = 3;
   localparam int OUT_W = 8;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_e;

   // Turn a line index into its one-hot line pattern.
   function automatic logic [OUT_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [OUT_W-1:0] oh;
      oh      = {OUT_W{1'b0}};
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/onehot_dec_cmd_buf.sv
// One-entry pending buffer holding the next line index while the current
// line is being driven. A write is only taken while the entry is empty.
module onehot_dec_cmd_buf
   import onehot_dec_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             rd_en,
   output logic [IDX_W-1:0] rd_idx,
   output logic             full
);

   logic             full_r;
   logic [IDX_W-1:0] idx_r;

   // Capture a new entry when empty, release it on a read.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_r <= 1'b0;
         idx_r  <= {IDX_W{1'b0}};
      end else if (wr_en && !full_r) begin
         full_r <= 1'b1;
         idx_r  <= wr_idx;
      end else if (rd_en) begin
         full_r <= 1'b0;
      end else begin
         full_r <= full_r;
      end
   end

   assign rd_idx = idx_r;
   assign full   = full_r;

endmodule

// File: rtl/onehot_decoder_3to8_seq.sv
// Sequential 3-to-8 one-hot decoder: each accepted index drives its line
// for HOLD_CYCLES cycles, followed by GAP_CYCLES all-zero cycles.
// Optional build macro ONEHOT_DEC_MASK_EN adds line_mask/drop_cnt: masked
// indices are discarded at the point they would start driving.
module onehot_decoder_3to8_seq
   import onehot_dec_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] in_idx,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out,
   output logic             busy,
   output logic             done
`ifdef ONEHOT_DEC_MASK_EN
   ,
   input  logic [OUT_W-1:0] line_mask,
   output logic [CNT_W-1:0] drop_cnt
`endif
);

   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   state_e           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [OUT_W-1:0] out_r;
   logic             done_r;
   // The pending entry is consumed at a start edge but only freed one edge
   // later, so in_ready stays low for the cycle after the drain.
   logic             drain_r;

   logic             pend_full_s;
   logic [IDX_W-1:0] pend_idx_s;
   logic             in_ready_s;
   logic             xfer_s;
   logic             pend_ok_s;
   logic             wr_en_s;
   logic             start_s;
   logic             start_pend_s;
   logic [IDX_W-1:0] start_idx_s;
   logic             masked_s;

   onehot_dec_cmd_buf u_cmd_buf (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en_s),
      .wr_idx (in_idx),
      .rd_en  (drain_r),
      .rd_idx (pend_idx_s),
      .full   (pend_full_s)
   );

   // Handshake, routing and decision of whether a line starts this edge.
   always_comb begin
      in_ready_s   = !rst && !pend_full_s;
      xfer_s       = in_valid && in_ready_s;
      pend_ok_s    = pend_full_s && !drain_r;
      wr_en_s      = xfer_s && (state_r != IDLE);
      start_s      = 1'b0;
      start_pend_s = 1'b0;
      start_idx_s  = pend_idx_s;
      case (state_r)
         IDLE: begin
            if (pend_ok_s) begin
               start_s      = 1'b1;
               start_pend_s = 1'b1;
            end else if (xfer_s) begin
               start_s     = 1'b1;
               start_idx_s = in_idx;
            end else begin
               start_s = 1'b0;
            end
         end
         ACTIVE: begin
            if ((cnt_r == 8'd0) && (GAP_CYCLES == 0) && pend_ok_s) begin
               start_s      = 1'b1;
               start_pend_s = 1'b1;
            end else begin
               start_s = 1'b0;
            end
         end
         GAP: begin
            if ((cnt_r == 8'd0) && pend_ok_s) begin
               start_s      = 1'b1;
               start_pend_s = 1'b1;
            end else begin
               start_s = 1'b0;
            end
         end
         default: begin
            start_s = 1'b0;
         end
      endcase
   end

`ifdef ONEHOT_DEC_MASK_EN
   logic [CNT_W-1:0] drop_r;

   assign masked_s = line_mask[start_idx_s];

   // Count discarded indices, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_r <= 8'd0;
      end else if (start_s && masked_s && (drop_r != 8'hFF)) begin
         drop_r <= drop_r + 8'd1;
      end else begin
         drop_r <= drop_r;
      end
   end

   assign drop_cnt = drop_r;
`else
   assign masked_s = 1'b0;
`endif

   // Hold/gap FSM with counter and registered one-hot/done outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
         out_r   <= 8'h00;
         done_r  <= 1'b0;
         drain_r <= 1'b0;
      end else begin
         drain_r <= start_s && start_pend_s;
         if (start_s) begin
            if (masked_s) begin
               state_r <= IDLE;
               cnt_r   <= 8'd0;
               out_r   <= 8'h00;
               done_r  <= 1'b0;
            end else begin
               state_r <= ACTIVE;
               cnt_r   <= HOLD_LD;
               out_r   <= idx_to_onehot(start_idx_s);
               done_r  <= (HOLD_LD == 8'd0);
            end
         end else begin
            case (state_r)
               IDLE: begin
                  cnt_r  <= cnt_r;
                  out_r  <= 8'h00;
                  done_r <= 1'b0;
               end
               ACTIVE: begin
                  if (cnt_r != 8'd0) begin
                     cnt_r  <= cnt_r - 8'd1;
                     done_r <= (cnt_r == 8'd1);
                  end else if (GAP_CYCLES > 0) begin
                     state_r <= GAP;
                     cnt_r   <= GAP_LD;
                     out_r   <= 8'h00;
                     done_r  <= 1'b0;
                  end else begin
                     state_r <= IDLE;
                     out_r   <= 8'h00;
                     done_r  <= 1'b0;
                  end
               end
               GAP: begin
                  done_r <= 1'b0;
                  if (cnt_r != 8'd0) begin
                     cnt_r <= cnt_r - 8'd1;
                  end else begin
                     state_r <= IDLE;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  cnt_r   <= 8'd0;
                  out_r   <= 8'h00;
                  done_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign in_ready = in_ready_s;
   assign out      = out_r;
   assign done     = done_r;
   assign busy     = (state_r != IDLE) || pend_full_s;

endmodule

// File: tb/tb_onehot_decoder_3to8_seq.sv
// Bench for onehot_decoder_3to8_seq: two instances (HOLD=4/GAP=1 and
// HOLD=3/GAP=0) share stimulus; each is tracked by a remaining-cycles model.
module tb_onehot_decoder_3to8_seq;

   localparam int HA = 4;
   localparam int GA = 1;
   localparam int HB = 3;
   localparam int GB = 0;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] in_idx;
   logic       in_valid;
   logic [7:0] d_out  [2];
   logic       d_done [2];
   logic       d_busy [2];
   logic       d_rdy  [2];
`ifdef ONEHOT_DEC_MASK_EN
   logic [7:0] line_mask;
   logic [7:0] d_drop [2];
`endif

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model: remaining hold/gap cycles, current line, one pending slot.
   int m_hold [2] = '{0, 0};
   int m_gap  [2] = '{0, 0};
   int m_line [2] = '{0, 0};
   bit m_pv   [2] = '{1'b0, 1'b0};
   bit m_lag  [2] = '{1'b0, 1'b0};
   int m_pidx [2] = '{0, 0};
   int m_drop [2] = '{0, 0};
   int p_hold [2] = '{HA, HB};
   int p_gap  [2] = '{GA, GB};

   always #5 clk = ~clk;

   onehot_decoder_3to8_seq #(.HOLD_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
      .clk(clk), .rst(rst), .in_idx(in_idx), .in_valid(in_valid),
      .in_ready(d_rdy[0]), .out(d_out[0]), .busy(d_busy[0]), .done(d_done[0])
`ifdef ONEHOT_DEC_MASK_EN
      , .line_mask(line_mask), .drop_cnt(d_drop[0])
`endif
   );

   onehot_decoder_3to8_seq #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
      .clk(clk), .rst(rst), .in_idx(in_idx), .in_valid(in_valid),
      .in_ready(d_rdy[1]), .out(d_out[1]), .busy(d_busy[1]), .done(d_done[1])
`ifdef ONEHOT_DEC_MASK_EN
      , .line_mask(line_mask), .drop_cnt(d_drop[1])
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_out(input int k);
      logic [7:0] one;
      one = 8'h01;
      return (m_hold[k] > 0) ? (one << m_line[k]) : 8'h00;
   endfunction

   task automatic m_start(input int k, input int idx);
`ifdef ONEHOT_DEC_MASK_EN
      if (line_mask[idx]) begin
         if (m_drop[k] < 255) m_drop[k]++;
         m_hold[k] = 0;
         m_gap[k]  = 0;
         return;
      end
`endif
      m_hold[k] = p_hold[k];
      m_gap[k]  = 0;
      m_line[k] = idx;
   endtask

   task automatic m_step(input int k);
      bit xfer, pok, idle;
      int pidx;
      if (rst) begin
         m_hold[k] = 0; m_gap[k] = 0; m_pv[k] = 1'b0; m_lag[k] = 1'b0; m_drop[k] = 0;
      end else begin
         xfer = in_valid && !m_pv[k];
         pok  = m_pv[k] && !m_lag[k];
         idle = (m_hold[k] == 0) && (m_gap[k] == 0);
         pidx = m_pidx[k];
         if (m_lag[k]) begin
            m_pv[k]  = 1'b0;
            m_lag[k] = 1'b0;
         end
         if (idle) begin
            if (pok) begin
               m_lag[k] = 1'b1;
               m_start(k, pidx);
            end else if (xfer) begin
               m_start(k, int'(in_idx));
            end
         end else begin
            if (m_hold[k] > 0) begin
               m_hold[k]--;
               if (m_hold[k] == 0) m_gap[k] = p_gap[k];
            end else begin
               m_gap[k]--;
            end
            if ((m_hold[k] == 0) && (m_gap[k] == 0) && pok) begin
               m_lag[k] = 1'b1;
               m_start(k, pidx);
            end
            if (xfer) begin
               m_pv[k]   = 1'b1;
               m_pidx[k] = int'(in_idx);
            end
         end
      end
   endtask

   // Advance the model on every rising edge using the inputs the DUT sees.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) m_step(k);
   end

   // Compare both instances against the model mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_%0d", k), d_out[k], exp_out(k));
            chk($sformatf("done_%0d", k), d_done[k], m_hold[k] == 1);
            chk($sformatf("busy_%0d", k), d_busy[k], (m_hold[k] > 0) || (m_gap[k] > 0) || m_pv[k]);
            chk($sformatf("ready_%0d", k), d_rdy[k], !rst && !m_pv[k]);
            chk($sformatf("onehot0_%0d", k), $onehot0(d_out[k]), 1'b1);
`ifdef ONEHOT_DEC_MASK_EN
            chk($sformatf("drop_%0d", k), d_drop[k], m_drop[k]);
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_idx = 3'd0;
`ifdef ONEHOT_DEC_MASK_EN
      line_mask = 8'h00;
`endif
      step(); step();
      chk_en = 1'b1;
      chk("rst_ready", d_rdy[0], 1'b0);
      rst = 1'b0;
      step();
      chk("rst_out", d_out[0], 8'h00);
      chk("rst_busy", d_busy[0], 1'b0);
      chk("rst_done", d_done[0], 1'b0);
      chk("rst_ready_rel", d_rdy[0], 1'b1);

      // Basic issue of idx 5.
      in_idx = 3'd5; in_valid = 1'b1;
      step();
      in_valid = 1'b0; in_idx = 3'bxxx;
      for (int c = 1; c <= 6; c++) begin
         chk("t1_out", d_out[0], (c <= 4) ? 8'h20 : 8'h00);
         chk("t1_done", d_done[0], c == 4);
         if (c == 2) chk("t1_model", exp_out(0), 8'h20);
         if (c == 6) chk("t1_busy", d_busy[0], 1'b0);
         step();
      end
      in_idx = 3'd0;

      // Queueing: idx 2 then idx 7 two cycles later.
      in_idx = 3'd2; in_valid = 1'b1;
      step();
      for (int c = 1; c <= 11; c++) begin
         in_valid = (c == 2);
         in_idx   = (c == 2) ? 3'd7 : 3'd2;
         chk("t2_out", d_out[0], (c <= 4) ? 8'h04 : ((c >= 6 && c <= 9) ? 8'h80 : 8'h00));
         chk("t2_ready", d_rdy[0], !(c >= 3 && c <= 6));
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // Back-to-back on the GAP=0 instance: idx 0 then idx 1.
      in_idx = 3'd0; in_valid = 1'b1;
      step();
      for (int c = 1; c <= 8; c++) begin
         in_valid = (c == 1);
         in_idx   = 3'd1;
         chk("t3_out", d_out[1], (c <= 3) ? 8'h01 : ((c <= 6) ? 8'h02 : 8'h00));
         chk("t3_done", d_done[1], (c == 3) || (c == 6));
         if (c == 5) chk("t3_model", exp_out(1), 8'h02);
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();

      // Reset mid-hold with an entry pending.
      in_idx = 3'd6; in_valid = 1'b1;
      step();
      in_idx = 3'd3;
      step();
      in_valid = 1'b0;
      chk("t4_pre_out", d_out[0], 8'h40);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_out", d_out[0], 8'h00);
      chk("t4_busy", d_busy[0], 1'b0);
      chk("t4_done", d_done[0], 1'b0);
      for (int c = 0; c < 8; c++) begin
         step();
         chk("t4_quiet", d_out[0] | d_out[1], 8'h00);
      end

      // Sweep all eight indices.
      for (int i = 0; i < 8; i++) begin
         logic [7:0] one;
         one = 8'h01;
         in_idx = 3'(i); in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         chk("t5_out", d_out[0], one << i);
         for (int c = 0; c < 6; c++) step();
      end

`ifdef ONEHOT_DEC_MASK_EN
      // Masked index 3 then index 4.
      line_mask = 8'h08;
      in_idx = 3'd3; in_valid = 1'b1;
      step();
      in_idx = 3'd4;
      chk("t6_out_drop", d_out[0], 8'h00);
      chk("t6_drop", d_drop[0], 8'd1);
      chk("t6_busy", d_busy[0], 1'b0);
      step();
      in_valid = 1'b0;
      chk("t6_out", d_out[0], 8'h10);
      for (int c = 0; c < 8; c++) step();
`endif

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_idx   = 3'($urandom_range(0, 7));
         rst      = ($urandom_range(0, 199) == 0);
`ifdef ONEHOT_DEC_MASK_EN
         line_mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
`endif
         step();
      end
      rst = 1'b0; in_valid = 1'b0;
      step(); step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/onehot_decoder_3to8_seq.md
Name: onehot_decoder_3to8_seq

Overview:
Sequential counterpart of the 8-to-3 priority encoder. Consumes a stream of 3-bit indices with a valid flag, the same shape the encoder produces. Drives the matching one-hot line for a programmable number of cycles, followed by an optional idle gap. A one-entry pending buffer lets the upstream queue the next index while the current line is held.

Parameters:
HOLD_CYCLES, 4, cycles each one-hot line stays asserted; legal range 1..255.
GAP_CYCLES, 1, cycles of all-zero output inserted after each hold; legal range 0..255.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous reset, active-high.
in_idx  input  3  line index to issue.
in_valid  input  1  in_idx is valid.
in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready at a rising edge.
out  output  8  registered one-hot output, or 8'h00.
busy  output  1  state != IDLE or pending buffer full.
done  output  1  one-cycle pulse during the last hold cycle of each issued line.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, out=8'h00, done=0, pending buffer empty, busy=0. in_ready=0 while rst=1.
- in_ready = !rst && !pend_valid, driven combinationally from registers. It is independent of in_valid.
- Routing: a transfer in IDLE loads directly into the hold path, bypassing the buffer. A transfer in any other state writes the pending buffer.
- States and transitions:
  - IDLE, on transfer: next cycle state=ACTIVE, out=1<<in_idx, cnt=HOLD_CYCLES-1. Latency from transfer edge to out is exactly 1 cycle.
  - ACTIVE: out held, cnt decrements each cycle. done=1 when cnt==0.
  - Leaving ACTIVE at cnt==0, first matching rule wins:
    - GAP_CYCLES>0: go to GAP, out=0, cnt=GAP_CYCLES-1.
    - GAP_CYCLES==0 and pending valid: reload ACTIVE with the pending index. Back-to-back, no zero cycle, done pulses again at the new line's end.
    - Otherwise: go to IDLE, out=0.
  - GAP: out=0, cnt decrements. At cnt==0, go to ACTIVE with the pending index if valid, else IDLE.
- Pending drain plus new transfer in the same cycle: in_ready is already 0 that cycle, so no transfer occurs. The buffer frees on the following cycle, and in_ready rises then.
- Counter width: 8 bits unsigned. Never underflows; it is reloaded on every state entry.
- out is always one-hot or zero; never more than one bit set.
- Reset mid-operation: abandons the held line and the pending entry immediately at that edge. No done pulse.
- Unknown/X on in_idx while in_valid=0 is ignored.

Optional Feature:
Macro ONEHOT_DEC_MASK_EN.
- Defined:
  - Adds input line_mask[7:0] and output drop_cnt[7:0].
  - An index whose line_mask bit is 1, sampled at the cycle the index would enter ACTIVE, is discarded: no ACTIVE, no GAP, no done.
  - The block proceeds as if that hold had just completed with GAP skipped: next pending entry or IDLE.
  - drop_cnt increments by 1 per discard, saturates at 8'hFF, reset to 0.
- Undefined: both ports are absent and every index is issued.

Decomposition:
- Package onehot_dec_pkg:
  - Constants IDX_W=3, OUT_W=8, CNT_W=8.
  - State enum typedef {IDLE, ACTIVE, GAP}.
- One sub-module, onehot_dec_cmd_buf: the one-entry pending buffer. Ports: wr_en, wr_idx, rd_en, rd_idx, full. Write takes priority only when empty.
- FSM, counter and decode stay in the top module.

Test Plan:
- Basic issue (HOLD=4, GAP=1): transfer idx=5 at edge 0 -> out=8'h20 on cycles 1-4, done=1 on cycle 4 only, out=0 on cycle 5, busy=0 from cycle 6.
- Queueing: transfer idx=2 at edge 0, idx=7 at edge 2 -> in_ready=0 on cycles 3..6. out=8'h04 on cycles 1-4, 0 on cycle 5, 8'h80 on cycles 6-9.
- Back-to-back (GAP=0): idx=0 then idx=1 queued -> out goes 8'h01 straight to 8'h02 with no zero cycle. Two done pulses, HOLD apart.
- Reset mid-hold: assert rst on cycle 2 of an active hold with an entry pending -> next cycle out=0, busy=0, done=0. No further output after release.
- Sweep: all eight indices issued in order -> exactly one bit set per hold, matching idx. out is never multi-hot.
- Mask (ONEHOT_DEC_MASK_EN): line_mask=8'h08, indices 3 then 4 -> idx 3 produces no output and drop_cnt=1. out=8'h10 follows without an intervening hold.
